// File: rtl/tvec_capture_axis_if.sv
// AXI-Stream bundle carrying captured beats out of tvec_capture_axis.
// Latency: none (wires only); backpressure via m_axis_tready from the slave side.
interface tvec_capture_axis_if #(
  parameter int TDATA_W = 64
);
  localparam int TKEEP_W = (TDATA_W + 7) / 8;

  logic [TDATA_W-1:0] m_axis_tdata;
  logic [TKEEP_W-1:0] m_axis_tkeep;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               m_axis_tlast;

  modport master (
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/tvec_capture_axis.sv
// Framed test-vector capture into an AXI-Stream source; ovf_cnt/frame_cnt exist only with TVEC_CAP_STATS_EN.
// Latency: a sample pushed at edge N is presented on m_axis after edge N+1.
// Backpressure: FIFO absorbs stalls; samples arriving while it is full are dropped and flagged.

// FIFO with a registered head; capacity is exactly DEPTH because an entry is only
// released on pop, the head register is a copy of mem[rd_ptr].
module tvec_cap_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  output logic         push_ok,
  input  logic         pop,
  output logic         head_vld,
  output logic [W-1:0] head_dat,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nxt;
  logic          full;
  logic          do_pop;
  logic          remain;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && head_vld;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || do_pop);
  assign rd_nxt  = rd_ptr + PW'(do_pop);
  // Entries already stored before this edge, excluding the one being written now.
  assign remain  = (rd_nxt != wr_ptr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      head_vld <= 1'b0;
      head_dat <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr   <= rd_nxt;
      head_vld <= remain;
      head_dat <= remain ? mem[rd_nxt[AW-1:0]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module tvec_capture_axis #(
  parameter int DATA_W     = 16,
  parameter int CHANNELS   = 4,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_free_run,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         trig,
  input  logic                         in_valid,
  input  logic [DATA_W*CHANNELS-1:0]   in_data,
  tvec_capture_axis_if.master          axis,
  output logic                         busy,
  output logic                         done,
  output logic                         ovf,
  output logic [15:0]                  ovf_cnt,
  output logic [15:0]                  frame_cnt
);
  localparam int TDATA_W = DATA_W * CHANNELS;
  localparam int SCNT_W  = $clog2(FRAME_LEN);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  logic [1:0]        state;
  logic              trig_q;
  logic [SCNT_W-1:0] samp_cnt;
  logic              trig_edge;
  logic              arm_ok;
  logic              trig_start;
  logic              push;
  logic              push_ok;
  logic              drop;
  logic              samp_last;
  logic              fifo_empty;
  logic              head_vld;
  logic [TDATA_W:0]  head_dat;

  assign trig_edge  = trig && !trig_q;
  assign arm_ok     = (state == ST_IDLE) && arm && !abort;
  assign trig_start = (state == ST_ARMED) && !abort && trig_edge && in_valid;
  assign push       = trig_start || ((state == ST_CAPTURE) && in_valid);
  assign drop       = push && !push_ok;
  assign samp_last  = (samp_cnt == SCNT_W'(FRAME_LEN - 1));
  assign done       = (state == ST_DRAIN) && fifo_empty && !head_vld;
  assign busy       = (state != ST_IDLE);

  tvec_cap_fifo #(
    .W     (TDATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat ({samp_last, in_data}),
    .push_ok  (push_ok),
    .pop      (axis.m_axis_tready),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .empty    (fifo_empty)
  );

  assign axis.m_axis_tdata  = head_dat[TDATA_W-1:0];
  assign axis.m_axis_tlast  = head_dat[TDATA_W];
  assign axis.m_axis_tvalid = head_vld;
  assign axis.m_axis_tkeep  = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      trig_q   <= 1'b0;
      samp_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      trig_q <= trig;
      case (state)
        ST_IDLE: begin
          if (arm_ok) begin
            ovf      <= 1'b0;
            samp_cnt <= '0;
            state    <= cfg_free_run ? ST_CAPTURE : ST_ARMED;
          end
        end
        ST_ARMED: begin
          // The triggering sample itself is beat 0 of the frame.
          if (abort) begin
            state <= ST_IDLE;
          end else if (trig_start && push_ok) begin
            samp_cnt <= SCNT_W'(1);
            state    <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (push_ok) begin
            samp_cnt <= samp_cnt + SCNT_W'(1);
            if (samp_last) state <= ST_DRAIN;
          end
        end
        default: begin
          if (done) state <= ST_IDLE;
        end
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

`ifdef TVEC_CAP_STATS_EN
  logic [15:0] ovf_cnt_q;
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (arm_ok) begin
        ovf_cnt_q <= '0;
      end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
        ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
      if (done) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign ovf_cnt   = ovf_cnt_q;
  assign frame_cnt = frame_cnt_q;
`else
  assign ovf_cnt   = '0;
  assign frame_cnt = '0;
`endif
endmodule

// File: tb/tb_tvec_capture_axis.sv
// Bench for tvec_capture_axis: directed scenarios plus random soak against a queue-based frame model.
module tb_tvec_capture_axis;
  localparam int DATA_W     = 16;
  localparam int CHANNELS   = 4;
  localparam int TDATA_W    = DATA_W * CHANNELS;
  localparam int FRAME_LEN  = 8;
  localparam int FIFO_DEPTH = 4;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic               rst_n;
  logic               cfg_free_run;
  logic               arm;
  logic               abort;
  logic               trig;
  logic               in_valid;
  logic [TDATA_W-1:0] in_data;
  logic               tready;
  logic               busy;
  logic               done;
  logic               ovf;
  logic [15:0]        ovf_cnt;
  logic [15:0]        frame_cnt;

  tvec_capture_axis_if #(.TDATA_W(TDATA_W)) axis_if ();
  assign axis_if.m_axis_tready = tready;

  tvec_capture_axis #(
    .DATA_W     (DATA_W),
    .CHANNELS   (CHANNELS),
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (tb_clk),
    .rst_n        (rst_n),
    .cfg_free_run (cfg_free_run),
    .arm          (arm),
    .abort        (abort),
    .trig         (trig),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .axis         (axis_if),
    .busy         (busy),
    .done         (done),
    .ovf          (ovf),
    .ovf_cnt      (ovf_cnt),
    .frame_cnt    (frame_cnt)
  );

  typedef struct {
    logic [TDATA_W-1:0] d;
    bit                 last;
    int                 t;
  } beat_t;

  typedef enum int {M_IDLE, M_ARMED, M_CAP, M_DRAIN} mode_e;

  // Reference: queue of stored beats stamped with the edge that wrote them.
  beat_t mq[$];
  beat_t obs_q[$];
  mode_e m_mode;
  int    ec;
  int    m_samp;
  int    m_ovfc;
  int    m_frames;
  bit    m_ovf;
  bit    m_trig_prev;
  int    total;
  int    bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_stat(input int v);
`ifdef TVEC_CAP_STATS_EN
    return 64'(v);
`else
    return 64'(v * 0);
`endif
  endfunction

  function automatic bit m_vis();
    return (mq.size() > 0) && (mq[0].t < ec);
  endfunction

  task automatic step();
    bit vis;
    bit tedge;
    bit was_empty;
    bit l;
    vis = m_vis();
    chk("tvalid", 64'(axis_if.m_axis_tvalid), 64'(vis));
    if (vis) begin
      chk("tdata", 64'(axis_if.m_axis_tdata), 64'(mq[0].d));
      chk("tlast", 64'(axis_if.m_axis_tlast), 64'(mq[0].last));
    end
    chk("tkeep", 64'(axis_if.m_axis_tkeep), 64'hFF);
    chk("busy", 64'(busy), 64'(m_mode != M_IDLE));
    chk("done", 64'(done), 64'(m_mode == M_DRAIN && mq.size() == 0));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("ovf_cnt", 64'(ovf_cnt), exp_stat(m_ovfc));
    chk("frame_cnt", 64'(frame_cnt), exp_stat(m_frames));
    if (axis_if.m_axis_tvalid === 1'b1 && tready === 1'b1)
      obs_q.push_back('{d: axis_if.m_axis_tdata, last: axis_if.m_axis_tlast, t: 0});
    @(posedge tb_clk);
    ec++;
    if (!rst_n) begin
      mq.delete();
      m_mode = M_IDLE; m_ovf = 0; m_ovfc = 0; m_frames = 0; m_samp = 0; m_trig_prev = 0;
    end else begin
      tedge     = trig && !m_trig_prev;
      was_empty = (mq.size() == 0);
      if (vis && tready) void'(mq.pop_front());
      case (m_mode)
        M_IDLE: if (arm && !abort) begin
          m_ovf = 0; m_ovfc = 0; m_samp = 0;
          m_mode = cfg_free_run ? M_CAP : M_ARMED;
        end
        M_ARMED: if (abort) m_mode = M_IDLE;
          else if (tedge && in_valid) begin
            mq.push_back('{d: in_data, last: 1'b0, t: ec});
            m_samp = 1; m_mode = M_CAP;
          end
        M_CAP: if (in_valid) begin
          if (mq.size() < FIFO_DEPTH) begin
            l = (m_samp == FRAME_LEN - 1);
            mq.push_back('{d: in_data, last: l, t: ec});
            m_samp++;
            if (l) m_mode = M_DRAIN;
          end else begin
            m_ovf = 1;
            if (m_ovfc < 65535) m_ovfc++;
          end
        end
        default: if (was_empty) begin
          m_mode = M_IDLE;
          m_frames = (m_frames + 1) % 65536;
        end
      endcase
      m_trig_prev = trig;
    end
    @(negedge tb_clk);
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    for (int i = 0; i < budget && m_mode != M_IDLE; i++) step();
    chk(tag, 64'(busy), 64'd0);
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_beats"}, 64'(obs_q.size()), 64'(FRAME_LEN));
    for (int i = 0; i < obs_q.size(); i++)
      chk({tag, "_last"}, 64'(obs_q[i].last), 64'(i == FRAME_LEN - 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TDATA_W-1:0] base;
    total = 0; bad = 0; ec = 0;
    mq.delete(); obs_q.delete();
    m_mode = M_IDLE; m_ovf = 0; m_ovfc = 0; m_frames = 0; m_samp = 0; m_trig_prev = 0;
    rst_n = 0; cfg_free_run = 1; arm = 0; abort = 0; trig = 0;
    in_valid = 0; in_data = '0; tready = 1;
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    chk("rst_tvalid", 64'(axis_if.m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(axis_if.m_axis_tdata), 64'd0);
    chk("rst_tlast", 64'(axis_if.m_axis_tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1;
    step();

    // Free-run ramp 0..7
    obs_q.delete();
    arm = 1; step(); arm = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      in_valid = 1; in_data = TDATA_W'(i); step();
    end
    in_valid = 0;
    run_until_idle("s1_idle", 40);
    chk_frame("s1");
    for (int i = 0; i < obs_q.size(); i++) chk("s1_dat", 64'(obs_q[i].d), 64'(i));
    chk("s1_frames", 64'(frame_cnt), exp_stat(1));

    // Triggered: lost edge first, then edge at sample 5 of a ramp
    obs_q.delete();
    base = {$urandom, $urandom};
    cfg_free_run = 0; arm = 1; step(); arm = 0;
    trig = 1; in_valid = 0; step();
    trig = 0; step();
    in_valid = 1; in_data = {$urandom, $urandom}; step(); step();
    chk("s2_still_armed", 64'(busy), 64'd1);
    chk("s2_no_beats", 64'(axis_if.m_axis_tvalid), 64'd0);
    for (int i = 0; i < 13; i++) begin
      in_valid = 1; trig = (i >= 5); in_data = base + TDATA_W'(i); step();
    end
    in_valid = 0; trig = 0;
    run_until_idle("s2_idle", 40);
    chk_frame("s2");
    if (obs_q.size() > 0) chk("s2_first", 64'(obs_q[0].d), 64'(base + TDATA_W'(5)));

    // Overflow with tready held low, then push+pop while full
    obs_q.delete();
    cfg_free_run = 1; tready = 0; arm = 1; step(); arm = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1; in_data = {$urandom, $urandom}; step();
    end
    chk("s3_ovf", 64'(ovf), 64'd1);
    chk("s3_ovf_cnt", 64'(ovf_cnt), exp_stat(8));
    tready = 1; in_data = {$urandom, $urandom}; step();
    chk("s3_pushpop_cnt", 64'(ovf_cnt), exp_stat(8));
    for (int i = 0; i < 20 && m_mode == M_CAP; i++) begin
      in_data = {$urandom, $urandom}; step();
    end
    in_valid = 0;
    run_until_idle("s3_idle", 40);
    chk_frame("s3");

    // Abort handling
    obs_q.delete();
    arm = 1; abort = 1; step(); arm = 0; abort = 0; step();
    chk("s4_arm_abort_busy", 64'(busy), 64'd0);
    cfg_free_run = 0; arm = 1; step(); arm = 0;
    abort = 1; step(); abort = 0;
    in_valid = 1; trig = 1; step(); trig = 0; in_valid = 0; step();
    chk("s4_armed_abort_busy", 64'(busy), 64'd0);
    chk("s4_armed_abort_beats", 64'(obs_q.size()), 64'd0);
    cfg_free_run = 1; arm = 1; step(); arm = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      in_valid = 1; abort = (i == 3); in_data = {$urandom, $urandom}; step();
    end
    in_valid = 0; abort = 0;
    run_until_idle("s4_idle", 40);
    chk_frame("s4");

    // Reset mid-capture with 3 beats queued
    tready = 0; arm = 1; step(); arm = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = {$urandom, $urandom}; step();
    end
    in_valid = 0; step();
    rst_n = 0; step();
    chk("s5_tvalid", 64'(axis_if.m_axis_tvalid), 64'd0);
    chk("s5_busy", 64'(busy), 64'd0);
    rst_n = 1; tready = 1; step();
    obs_q.delete();
    arm = 1; step(); arm = 0;
    for (int i = 0; i < 200 && m_mode == M_CAP; i++) begin
      in_valid = ($urandom % 2) == 0; tready = ($urandom % 2) == 0;
      in_data = {$urandom, $urandom}; step();
    end
    in_valid = 0; tready = 1;
    run_until_idle("s5_idle", 60);
    chk_frame("s5");
    chk("s5_frames", 64'(frame_cnt), exp_stat(1));

    // Random soak
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom % 300) != 0;
      arm = ($urandom % 8) == 0;
      abort = ($urandom % 20) == 0;
      trig = ($urandom % 3) == 0;
      if (($urandom % 16) == 0) cfg_free_run = ~cfg_free_run;
      in_valid = ($urandom % 4) != 0;
      tready = ($urandom % 3) != 0;
      in_data = {$urandom, $urandom};
      step();
    end
    rst_n = 1; arm = 0; abort = 1; trig = 0; tready = 1; in_valid = 1;
    run_until_idle("soak_idle", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
